// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz timing constants and coordinate type, used by vga_sync_gen
// and the image pixel controller.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-clock enable: one-clk pulse every CLK_DIV system clocks, held high when CLK_DIV=1.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic p_tick
);

  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivOne  = 1;

  logic [DivW-1:0] r_div;
  logic [DivW-1:0] w_div_next;
  logic            r_p_tick;

  always_comb begin
    w_div_next = (r_div == DivLast) ? '0 : r_div + DivOne;
  end

  // Tick is registered from the next divider value so it is 0 in reset even for CLK_DIV=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_p_tick <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      r_p_tick <= (w_div_next == DivLast);
    end
  end

  assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel counters, registered sync/video decode and line/frame strobes.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync/video_on by one pixel (for 1-cycle image ROMs).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
  parameter int unsigned H_FP            = DEF_H_FP,
  parameter int unsigned H_SYNC          = DEF_H_SYNC,
  parameter int unsigned H_BP            = DEF_H_BP,
  parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
  parameter int unsigned V_FP            = DEF_V_FP,
  parameter int unsigned V_SYNC          = DEF_V_SYNC,
  parameter int unsigned V_BP            = DEF_V_BP,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       p_tick,
  output logic [9:0] curr_x,
  output logic [9:0] curr_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t XLast   = coord_t'(HTotal - 1);
  localparam coord_t XActive = coord_t'(H_ACTIVE);
  localparam coord_t HsStart = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HsEnd   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t YLast   = coord_t'(VTotal - 1);
  localparam coord_t YActive = coord_t'(V_ACTIVE);
  localparam coord_t VsStart = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VsEnd   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t One     = coord_t'(1);

  localparam logic SyncOff = SYNC_ACTIVE_LOW;
  localparam logic SyncOn  = ~SYNC_ACTIVE_LOW;

  logic   w_p_tick;
  coord_t r_x, r_y;
  coord_t w_x_next, w_y_next;
  logic   r_video_on, r_hsync, r_vsync;
  logic   w_video_next, w_hsync_next, w_vsync_next;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .p_tick (w_p_tick)
  );

  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_p_tick) begin
      if (r_x == XLast) begin
        w_x_next = '0;
        w_y_next = (r_y == YLast) ? '0 : r_y + One;
      end else begin
        w_x_next = r_x + One;
      end
    end
  end

  // Decode from next-state counters so the registered flags line up with curr_x/curr_y.
  always_comb begin
    w_video_next = (w_x_next < XActive) && (w_y_next < YActive);
    w_hsync_next = ((w_x_next >= HsStart) && (w_x_next <= HsEnd)) ? SyncOn : SyncOff;
    w_vsync_next = ((w_y_next >= VsStart) && (w_y_next <= VsEnd)) ? SyncOn : SyncOff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_video_on <= 1'b0;
      r_hsync    <= SyncOff;
      r_vsync    <= SyncOff;
    end else begin
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_video_on <= w_video_next;
      r_hsync    <= w_hsync_next;
      r_vsync    <= w_vsync_next;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic r_video_on_al, r_hsync_al, r_vsync_al;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_video_on_al <= 1'b0;
      r_hsync_al    <= SyncOff;
      r_vsync_al    <= SyncOff;
    end else if (w_p_tick) begin
      r_video_on_al <= r_video_on;
      r_hsync_al    <= r_hsync;
      r_vsync_al    <= r_vsync;
    end
  end

  assign video_on = r_video_on_al;
  assign hsync    = r_hsync_al;
  assign vsync    = r_vsync_al;
`else
  assign video_on = r_video_on;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
`endif

  assign p_tick    = w_p_tick;
  assign curr_x    = r_x;
  assign curr_y    = r_y;
  assign line_end  = w_p_tick && (r_x == XLast);
  assign frame_end = line_end && (r_y == YLast);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a reduced 15x8 geometry (sync x=10..12, y=5..6).
module tb_vga_sync_gen;

  localparam int HT = 15;
  localparam int VT = 8;
`ifdef VGA_SYNC_ALIGN_EN
  localparam int Lag = 1;
`else
  localparam int Lag = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p_tick, video_on, hsync, vsync, line_end, frame_end;
  logic [9:0] curr_x, curr_y;
  logic       p_tick1, video_on1, hsync1, vsync1, line_end1, frame_end1;
  logic [9:0] curr_x1, curr_y1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV (4), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .SYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .p_tick (p_tick), .curr_x (curr_x), .curr_y (curr_y),
    .video_on (video_on), .hsync (hsync), .vsync (vsync),
    .line_end (line_end), .frame_end (frame_end)
  );

  vga_sync_gen #(
    .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .SYNC_ACTIVE_LOW (1'b1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .p_tick (p_tick1), .curr_x (curr_x1), .curr_y (curr_y1),
    .video_on (video_on1), .hsync (hsync1), .vsync (vsync1),
    .line_end (line_end1), .frame_end (frame_end1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Pixel whose flags are on the outputs while the counters read (x,y).
  function automatic void shown_pixel(input int x, input int y, output int px, output int py);
    px = x;
    py = y;
    if (Lag == 1) begin
      if (x == 0) begin
        px = HT - 1;
        py = (y == 0) ? VT - 1 : y - 1;
      end else begin
        px = x - 1;
      end
    end
  endfunction

  task automatic wait_xy(input int x, input int y);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (curr_x == 10'(x) && curr_y == 10'(y)) return;
    end
    check_eq($sformatf("reach_x%0d_y%0d", x, y), {22'd0, curr_x}, x);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 8; i++) begin
      if (p_tick) return;
      @(negedge clk);
    end
    check_eq("wait_tick", p_tick, 1);
  endtask

  task automatic probe(input int x, input int y);
    int px, py;
    wait_xy(x, y);
    shown_pixel(x, y, px, py);
    check_eq($sformatf("video@%0d,%0d", x, y), video_on, (px < 8 && py < 4) ? 1 : 0);
    check_eq($sformatf("hsync@%0d,%0d", x, y), hsync, (px >= 10 && px <= 12) ? 0 : 1);
    check_eq($sformatf("vsync@%0d,%0d", x, y), vsync, (py >= 5 && py <= 6) ? 0 : 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_x"}, {22'd0, curr_x}, 0);
    check_eq({tag, "_y"}, {22'd0, curr_y}, 0);
    check_eq({tag, "_video"}, video_on, 0);
    check_eq({tag, "_hsync"}, hsync, 1);
    check_eq({tag, "_vsync"}, vsync, 1);
    check_eq({tag, "_ptick"}, p_tick, 0);
    check_eq({tag, "_lend"}, line_end, 0);
    check_eq({tag, "_fend"}, frame_end, 0);
  endtask

  int n_tick, n_vid, n_hs, n_vs, n_lend, n_fend, n_bad_x, n_bad_gap, n_bad_fend, gap;
  logic [9:0] prev_x;
  logic       prev_tick, done;

  initial begin
    // Reset held for 10 clocks.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    check_eq("rst_ptick1", p_tick1, 0);
    rst_n = 1'b1;

    @(negedge clk);
    check_eq("rel1_x", {22'd0, curr_x}, 0);
    check_eq("rel1_ptick", p_tick, 0);
    check_eq("rel1_video", video_on, (Lag == 1) ? 0 : 1);
    check_eq("rel1_ptick1", p_tick1, 1);
    check_eq("rel1_x1", {22'd0, curr_x1}, 0);
    @(negedge clk);
    check_eq("rel2_x1", {22'd0, curr_x1}, 1);
    check_eq("rel2_ptick1", p_tick1, 1);
    @(negedge clk);
    check_eq("rel3_x1", {22'd0, curr_x1}, 2);
    check_eq("rel3_x", {22'd0, curr_x}, 0);
    wait_xy(1, 0);
    check_eq("first_video", video_on, 1);

    // Asynchronous reset mid-line, away from any clock edge.
    wait_xy(6, 0);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    probe(7, 0);
    probe(8, 0);
    probe(9, 0);
    probe(10, 0);
    probe(11, 0);
    probe(12, 0);
    probe(13, 0);
    probe(14, 0);
    check_eq("lend_pre_tick", line_end, 0);
    wait_tick();
    check_eq("lend_x14", line_end, 1);
    check_eq("fend_y0", frame_end, 0);
    @(negedge clk);
    check_eq("wrap_x", {22'd0, curr_x}, 0);
    check_eq("wrap_y", {22'd0, curr_y}, 1);
    check_eq("wrap_lend", line_end, 0);
    probe(3, 3);
    probe(8, 3);
    probe(0, 4);
    probe(14, 4);
    probe(0, 5);
    probe(10, 5);
    probe(14, 6);
    probe(0, 7);
    probe(14, 7);
    wait_tick();
    check_eq("fend_last", frame_end, 1);
    check_eq("lend_last", line_end, 1);
    @(negedge clk);
    check_eq("fwrap_x", {22'd0, curr_x}, 0);
    check_eq("fwrap_y", {22'd0, curr_y}, 0);
    check_eq("fwrap_fend", frame_end, 0);

    // Whole-frame statistics between two consecutive frame_end pulses.
    for (int i = 0; i < 600 && !frame_end; i++) @(negedge clk);
    check_eq("stats_start", frame_end, 1);
    n_tick = 0; n_vid = 0; n_hs = 0; n_vs = 0; n_lend = 0; n_fend = 0;
    n_bad_x = 0; n_bad_gap = 0; n_bad_fend = 0; gap = 0;
    prev_x = curr_x;
    prev_tick = p_tick;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      gap++;
      if (curr_x != prev_x && !prev_tick) n_bad_x++;
      if (p_tick) begin
        n_tick++;
        if (gap != 4) n_bad_gap++;
        gap = 0;
        if (video_on) n_vid++;
        if (!hsync) n_hs++;
        if (!vsync) n_vs++;
      end
      if (line_end) n_lend++;
      if (frame_end) begin
        n_fend++;
        if (!line_end) n_bad_fend++;
        done = 1'b1;
      end
      prev_x = curr_x;
      prev_tick = p_tick;
    end
    check_eq("frame_ticks", n_tick, 120);
    check_eq("video_ticks", n_vid, 32);
    check_eq("hsync_ticks", n_hs, 24);
    check_eq("vsync_ticks", n_vs, 30);
    check_eq("line_ends", n_lend, 8);
    check_eq("frame_ends", n_fend, 1);
    check_eq("x_change_no_tick", n_bad_x, 0);
    check_eq("tick_gap_not_4", n_bad_gap, 0);
    check_eq("fend_without_lend", n_bad_fend, 0);
    check_eq("ptick1_held", p_tick1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
